fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Front-end fetch unit plus circular instruction queue that sources the issue stage.
- Drives instruction memory, holds fetched instructions, and presents the head instruction as a decoded pci_t to the reorder buffer.
- The reorder buffer pops the head with dequeue.
- Handles branch/jalr redirect on flush, including a read that is still outstanding when the flush arrives.

Parameters:
- width, 32, address/data width.
- size, 8, queue depth in entries (power of two).
- reset_pc, 32'h00000060, fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instr_mem_read  out  1  memory read request
- instr_mem_address  out  width  fetch address
- instr_mem_rdata  in  width  returned instruction word
- instr_mem_resp  in  1  read complete; rdata valid this cycle
- dequeue  in  1  reorder buffer consumes the head (or the bypassed) instruction this cycle
- flush_valid  in  1  mispredict/jalr redirect
- flush_pc  in  width  redirect target
- pci  out  pci_t  head instruction decoded; the bypass instruction when empty
- instr_q_empty  out  1  queue holds zero entries
- fetch_resp_valid  out  1  bypass instruction on pci is valid (feeds the reorder buffer's instr_mem_resp input)

Behaviour:
- Reset:
  - count=0, head=tail=0, state=IDLE, fetch_pc=reset_pc.
  - instr_mem_read=0, instr_q_empty=1, fetch_resp_valid=0.
  - pci = all-zero with opcode op_imm.
- Entry storage: {pc, instr word, br_pred}. pci is built combinationally from the entry:
  - opcode=instr[6:0], rd=instr[11:7], pc=entry pc.
  - is_br_instr=(opcode==op_br).
  - branch_pc=pc+sext(B-imm).
  - br_pred=stored prediction. Other fields are decoded per the pci_t definition.
- Static prediction at fetch:
  - op_br: predict taken iff B-imm is negative. Next fetch_pc = taken ? pc+B-imm : pc+4.
  - op_jal: next = pc+J-imm, br_pred=1.
  - All others, including jalr: next = pc+4, br_pred=0.
- FSM states: IDLE, FETCH, DISCARD.
  - IDLE: read=0. If flush_valid: fetch_pc<=flush_pc, go FETCH. Else if count<size: go FETCH.
  - FETCH: read=1, address=fetch_pc, held stable until resp.
    - On resp without flush: enqueue (or bypass), fetch_pc<=next.
    - After that resp: stay FETCH if post-cycle count<size, else go IDLE.
  - FETCH with flush and no resp: latch redirect_pc<=flush_pc, go DISCARD. Address stays unchanged.
  - FETCH with flush and resp in the same cycle: drop the data, fetch_pc<=flush_pc, stay FETCH. The new address appears next cycle.
  - DISCARD: read=1 on the old address. Flush again updates redirect_pc. On resp: drop the data, fetch_pc<=redirect_pc, go FETCH.
- Bypass:
  - fetch_resp_valid = (state==FETCH) & instr_mem_resp & (count==0) & ~flush_valid. When it is high, pci reflects the incoming word.
  - If dequeue is also high, the word is not stored.
- Simultaneous dequeue and enqueue with count>0: head and tail both advance; count is unchanged.
- A full queue never coincides with a response, because at most one read is outstanding and issue requires count<size.
- Flush priority:
  - Flush clears the queue: count=0, head=tail=0.
  - It suppresses enqueue, dequeue and bypass that cycle, and overrides any pending transition.
- Pointers wrap modulo size.
- dequeue while empty with no bypass is ignored.
- rst overrides everything, including mid-read. The memory side must tolerate the abandoned request.

Test Plan:
- Reset then 4 sequential addi, zero wait states -> addresses 0x60, 0x64, 0x68, 0x6C; with no dequeue, count=4 and pci.pc=0x60.
- dequeue held low -> after 8 fills, instr_mem_read=0 in IDLE. A single dequeue -> FETCH re-entered and pci.pc advances by 4.
- Empty queue, resp with dequeue=1 -> fetch_resp_valid=1, pci.pc=fetch address, count stays 0.
- Backward beq at 0x80 with imm=-16 -> br_pred=1 and next address 0x70; jal +0x20 at 0x70 -> next address 0x90.
- flush_valid with flush_pc=0x200 while a read is pending at 0x90 -> 0x90 held until resp, data dropped, next address 0x200, queue empty, no fetch_resp_valid.
- flush and resp in the same cycle -> data dropped, address 0x200 the following cycle; rst mid-FETCH -> address 0x60, count 0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue_pkg: RV32 opcode constants, immediate extractors and the decoded
// instruction record (pci_t) handed to the reorder buffer.
package fetch_queue_pkg;

    localparam int unsigned xlen = 32;

    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    typedef struct packed {
        logic [xlen-1:0] pc;
        logic [xlen-1:0] instr;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [xlen-1:0] imm;
        logic [xlen-1:0] branch_pc;
        logic            is_br_instr;
        logic            br_pred;
    } pci_t;

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Record presented when nothing valid is available: all-zero nop-class op_imm.
    function automatic pci_t idle_pci();
        pci_t p;
        p        = '0;
        p.opcode = op_imm;
        return p;
    endfunction

    // Field split and immediate selection for one fetched word.
    function automatic pci_t decode(input logic [31:0] pc, input logic [31:0] instr,
                                    input logic br_pred);
        pci_t p;
        p             = '0;
        p.pc          = pc;
        p.instr       = instr;
        p.opcode      = instr[6:0];
        p.rd          = instr[11:7];
        p.funct3      = instr[14:12];
        p.rs1         = instr[19:15];
        p.rs2         = instr[24:20];
        p.funct7      = instr[31:25];
        case (instr[6:0])
            op_imm, op_load, op_jalr: p.imm = imm_i(instr);
            op_store:                 p.imm = imm_s(instr);
            op_br:                    p.imm = imm_b(instr);
            op_lui, op_auipc:         p.imm = imm_u(instr);
            op_jal:                   p.imm = imm_j(instr);
            default:                  p.imm = '0;
        endcase
        p.branch_pc   = pc + imm_b(instr);
        p.is_br_instr = (instr[6:0] == op_br);
        p.br_pred     = br_pred;
        return p;
    endfunction

endpackage

// fetch_queue: instruction fetch unit with static branch prediction feeding a
// circular instruction queue; the head (or a bypassed word) is presented as pci.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   instr_mem_read/address       read request, address held until response
//   instr_mem_rdata/resp         returned word and its one-cycle valid
//   dequeue                      reorder buffer consumes pci this cycle
//   flush_valid, flush_pc        redirect; clears the queue
//   pci                          decoded head or bypass instruction
//   instr_q_empty                queue holds no entries
//   fetch_resp_valid             pci carries the bypassed incoming word
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     width    = 32,
    parameter int unsigned     size     = 8,
    parameter logic [width-1:0] reset_pc = 'h60
) (
    input  logic             clk,
    input  logic             rst,
    output logic             instr_mem_read,
    output logic [width-1:0] instr_mem_address,
    input  logic [width-1:0] instr_mem_rdata,
    input  logic             instr_mem_resp,
    input  logic             dequeue,
    input  logic             flush_valid,
    input  logic [width-1:0] flush_pc,
    output pci_t             pci,
    output logic             instr_q_empty,
    output logic             fetch_resp_valid
);

    localparam int unsigned ptr_w = $clog2(size);
    localparam int unsigned cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(size);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t             state;
    logic [width-1:0]   fetch_pc;
    logic [width-1:0]   redirect_pc;
    logic [cnt_w-1:0]   count;
    logic [ptr_w-1:0]   head;
    logic [ptr_w-1:0]   tail;

    logic [width-1:0]   q_pc    [size];
    logic [width-1:0]   q_instr [size];
    logic               q_pred  [size];

    logic               resp_ok;
    logic               bypass;
    logic               enq;
    logic               deq;
    logic [cnt_w-1:0]   count_next;
    logic [width-1:0]   b_off;
    logic [width-1:0]   j_off;
    logic               is_br;
    logic               is_jal;
    logic               br_taken;
    logic               pred_taken;
    logic [width-1:0]   next_pc;

    // Queue traffic this cycle; flush suppresses enqueue, dequeue and bypass.
    always_comb begin
        resp_ok    = (state == FETCH) & instr_mem_resp & ~flush_valid;
        bypass     = resp_ok & (count == '0);
        enq        = resp_ok & ~(bypass & dequeue);
        deq        = ~flush_valid & dequeue & (count != '0);
        count_next = count + cnt_w'(enq) - cnt_w'(deq);
    end

    // Static prediction on the returning word: backward branches and jal taken.
    always_comb begin
        b_off      = width'(imm_b(xlen'(instr_mem_rdata)));
        j_off      = width'(imm_j(xlen'(instr_mem_rdata)));
        is_br      = (instr_mem_rdata[6:0] == op_br);
        is_jal     = (instr_mem_rdata[6:0] == op_jal);
        br_taken   = is_br & b_off[width-1];
        pred_taken = br_taken | is_jal;
        if (br_taken) begin
            next_pc = fetch_pc + b_off;
        end else if (is_jal) begin
            next_pc = fetch_pc + j_off;
        end else begin
            next_pc = fetch_pc + width'(4);
        end
    end

    // Fetch FSM, fetch address and queue bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= reset_pc;
            redirect_pc <= reset_pc;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (flush_valid) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                count <= count_next;
                if (enq) tail <= tail + ptr_w'(1);
                if (deq) head <= head + ptr_w'(1);
            end

            case (state)
                IDLE: begin
                    if (flush_valid) begin
                        fetch_pc <= flush_pc;
                        state    <= FETCH;
                    end else if (count < full_cnt) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (flush_valid && instr_mem_resp) begin
                        // Read already finished: redirect immediately, drop the word.
                        fetch_pc <= flush_pc;
                    end else if (flush_valid) begin
                        // Read still outstanding: wait it out on the old address.
                        redirect_pc <= flush_pc;
                        state       <= DISCARD;
                    end else if (instr_mem_resp) begin
                        fetch_pc <= next_pc;
                        if (count_next == full_cnt) state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (instr_mem_resp) begin
                        fetch_pc <= flush_valid ? flush_pc : redirect_pc;
                        state    <= FETCH;
                    end else if (flush_valid) begin
                        redirect_pc <= flush_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[tail]    <= fetch_pc;
            q_instr[tail] <= instr_mem_rdata;
            q_pred[tail]  <= pred_taken;
        end
    end

    // Head / bypass presentation.
    always_comb begin
        if (bypass) begin
            pci = decode(xlen'(fetch_pc), xlen'(instr_mem_rdata), pred_taken);
        end else if (count != '0) begin
            pci = decode(xlen'(q_pc[head]), xlen'(q_instr[head]), q_pred[head]);
        end else begin
            pci = idle_pci();
        end
    end

    assign instr_mem_read    = (state != IDLE);
    assign instr_mem_address = fetch_pc;
    assign instr_q_empty     = (count == '0);
    assign fetch_resp_valid  = bypass;

endmodule
